// File: rtl/vga_pattern_gen_if.sv
// Pattern-generator bus: timing enable, pattern controls and the video outputs.
// The master side (display controller or bench) drives the controls and
// receives the video; the generator sits on the slave side.
// There is no valid/ready handshake: the video outputs are a free-running stream,
// one pixel per clock. de is the only qualifier. pix_x/pix_y carry meaning only
// while de is high.
interface vga_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic                  en;
  logic [1:0]            mode;
  logic [3*DATA_W-1:0]   box_color;
  logic                  hs;
  logic                  vs;
  logic                  de;
  logic [3*DATA_W-1:0]   rgb;
  logic [15:0]           pix_x;
  logic [15:0]           pix_y;
  logic                  frame_start;

  modport master (
    output en, mode, box_color,
    input  hs, vs, de, rgb, pix_x, pix_y, frame_start
  );

  modport slave (
    input  en, mode, box_color,
    output hs, vs, de, rgb, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with test patterns: colour bars, checkerboard,
// bars with a bouncing box, and solid colour. Every output is registered
// one cycle after the counter state it is derived from.
// H_ACTIVE+H_FP+H_SYNC+H_BP and the vertical sum must stay at or below 65535.
// BOX_SIZE must be smaller than both H_ACTIVE and V_ACTIVE.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 8,
  parameter int BOX_SIZE = 150,
  parameter int BAR_W    = 128,
  parameter int CHK_LOG2 = 5
) (
  input logic              clk,
  input logic              rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_ACT     = 16'(H_ACTIVE);
  localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
  localparam logic [15:0] HS_BEG    = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_ACT     = 16'(V_ACTIVE);
  localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
  localparam logic [15:0] VS_BEG    = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BOX_X_MAX = 16'(H_ACTIVE - BOX_SIZE);
  localparam logic [15:0] BOX_Y_MAX = 16'(V_ACTIVE - BOX_SIZE);
  localparam logic [15:0] BOX_SPAN  = 16'(BOX_SIZE - 1);
  localparam logic [15:0] BAR_LAST  = 16'(BAR_W - 1);

  localparam logic [DATA_W-1:0] CH_FULL = '1;
  localparam logic [DATA_W-1:0] CH_ZERO = '0;

  // Raster counters and the running bar tracker that follows h_cnt
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [15:0] bar_px_q, bar_px_d;   // pixel offset inside current bar
  logic [3:0]  bar_idx_q, bar_idx_d; // bar number, saturates at 8 (black)

  // Frame-level state
  logic [1:0]  active_mode_q, active_mode_d;
  logic [15:0] box_x_q, box_x_d;
  logic [15:0] box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;

  // Registered outputs
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                de_q, de_d;
  logic [3*DATA_W-1:0] rgb_q, rgb_d;
  logic [15:0]         pix_x_q, pix_x_d;
  logic [15:0]         pix_y_q, pix_y_d;
  logic                fs_q, fs_d;

  logic                h_last;
  logic                v_last;
  logic                at_origin;
  logic [1:0]          mode_eff;
  logic                active;
  logic                in_box;
  logic [3*DATA_W-1:0] bar_rgb;
  logic [3*DATA_W-1:0] chk_rgb;

  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign at_origin = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);

  // Counter advance; a low enable parks the raster at (0,0)
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (!bus.en) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_last) begin
      h_cnt_d   = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
      v_cnt_d   = v_last ? 16'd0 : v_cnt_q + 16'd1;
    end else begin
      h_cnt_d = h_cnt_q + 16'd1;
      if (bar_px_q == BAR_LAST) begin
        bar_px_d = '0;
        if (bar_idx_q != 4'd8) bar_idx_d = bar_idx_q + 4'd1;
      end else begin
        bar_px_d = bar_px_q + 16'd1;
      end
    end
  end

  // Box bounce: one step per enabled frame, reversing and moving on the same update
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (bus.en && h_last && v_last) begin
      if (dir_x_q) begin
        if (box_x_q == BOX_X_MAX) begin
          dir_x_d = 1'b0;
          box_x_d = box_x_q - 16'd1;
        end else begin
          box_x_d = box_x_q + 16'd1;
        end
      end else begin
        if (box_x_q == 16'd0) begin
          dir_x_d = 1'b1;
          box_x_d = 16'd1;
        end else begin
          box_x_d = box_x_q - 16'd1;
        end
      end
      if (dir_y_q) begin
        if (box_y_q == BOX_Y_MAX) begin
          dir_y_d = 1'b0;
          box_y_d = box_y_q - 16'd1;
        end else begin
          box_y_d = box_y_q + 16'd1;
        end
      end else begin
        if (box_y_q == 16'd0) begin
          dir_y_d = 1'b1;
          box_y_d = 16'd1;
        end else begin
          box_y_d = box_y_q - 16'd1;
        end
      end
    end
  end

  // Mode is latched at (0,0) and already applies to that first pixel
  always_comb begin
    mode_eff      = (bus.en && at_origin) ? bus.mode : active_mode_q;
    active_mode_d = mode_eff;
  end

  // Pixel colour and sync levels for the current counter position
  always_comb begin
    active  = bus.en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    in_box  = (h_cnt_q >= box_x_q) && (h_cnt_q <= box_x_q + BOX_SPAN) &&
              (v_cnt_q >= box_y_q) && (v_cnt_q <= box_y_q + BOX_SPAN);
    // Bar index bits map straight onto channel on/off: R=~b1, G=~b2, B=~b0
    if (bar_idx_q[3]) begin
      bar_rgb = '0;
    end else begin
      bar_rgb = {bar_idx_q[1] ? CH_ZERO : CH_FULL,
                 bar_idx_q[2] ? CH_ZERO : CH_FULL,
                 bar_idx_q[0] ? CH_ZERO : CH_FULL};
    end
    chk_rgb = (h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2]) ? {3{CH_FULL}} : '0;

    rgb_d = '0;
    if (active) begin
      case (mode_eff)
        2'd0:    rgb_d = bar_rgb;
        2'd1:    rgb_d = chk_rgb;
        2'd2:    rgb_d = in_box ? bus.box_color : bar_rgb;
        default: rgb_d = bus.box_color;
      endcase
    end
    de_d    = active;
    pix_x_d = active ? h_cnt_q : 16'd0;
    pix_y_d = active ? v_cnt_q : 16'd0;
    fs_d    = bus.en && at_origin;
    hs_d    = (bus.en && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = (bus.en && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Raster, bar tracker, box and mode state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_px_q      <= '0;
      bar_idx_q     <= '0;
      active_mode_q <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
      active_mode_q <= active_mode_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
    end
  end

  // Output registers, all aligned one cycle behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.de          = de_q;
  assign bus.rgb         = rgb_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a small raster: random mode/colour/enable
// stimulus, a frame-level reference model feeding an expected queue, and a
// monitor that pops one expected pixel per clock.
module tb_vga_pattern_gen;

  localparam int HA   = 20;
  localparam int HFP  = 2;
  localparam int HSY  = 3;
  localparam int HBP  = 1;
  localparam int VA   = 8;
  localparam int VFP  = 1;
  localparam int VSY  = 2;
  localparam int VBP  = 1;
  localparam bit HSP  = 1'b1;
  localparam bit VSP  = 1'b0;
  localparam int DW   = 8;
  localparam int BOX  = 4;
  localparam int BARW = 2;
  localparam int CHK  = 1;
  localparam int HT   = HA + HFP + HSY + HBP;
  localparam int VT   = VA + VFP + VSY + VBP;
  localparam int FR   = HT * VT;
  localparam int OW   = 3 + 24 + 16 + 16 + 1;
  localparam int MAX_ERR = 50;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.DATA_W(DW)) bus ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .DATA_W(DW),
    .BOX_SIZE(BOX), .BAR_W(BARW), .CHK_LOG2(CHK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // reference model: raster position, completed enabled frames, latched mode
  int m_h, m_v, m_frames;
  logic [1:0] m_mode;

  // Box coordinate as a triangle wave of the frame count, period 2*span
  function automatic int tri_pos(input int n, input int span);
    int p;
    p = n % (2 * span);
    return (p <= span) ? p : 2 * span - p;
  endfunction

  function automatic logic [23:0] bar_color(input int x);
    int idx;
    idx = x / BARW;
    return (idx < 8) ? bar_tab[idx] : 24'h000000;
  endfunction

  function automatic logic [OW-1:0] idle_vec();
    return {!HSP, !VSP, 1'b0, 24'h0, 16'h0, 16'h0, 1'b0};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_frames = 0; m_mode = 2'd0;
  endtask

  // Expected output for the inputs presented at the coming clock edge
  task automatic model_step(input logic en, input logic [1:0] md, input logic [23:0] col);
    logic hs, vs, de, fs;
    logic [23:0] rgb;
    int bx, by;
    if (!en) begin
      exp_q.push_back(idle_vec());
      m_h = 0; m_v = 0;
    end else begin
      if (m_h == 0 && m_v == 0) m_mode = md;
      de = (m_h < HA) && (m_v < VA);
      hs = (m_h >= HA + HFP && m_h < HA + HFP + HSY) ? HSP : !HSP;
      vs = (m_v >= VA + VFP && m_v < VA + VFP + VSY) ? VSP : !VSP;
      fs = (m_h == 0) && (m_v == 0);
      bx = tri_pos(m_frames, HA - BOX);
      by = tri_pos(m_frames, VA - BOX);
      rgb = 24'h0;
      if (de) begin
        case (m_mode)
          2'd0: rgb = bar_color(m_h);
          2'd1: rgb = (((m_h >> CHK) ^ (m_v >> CHK)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
          2'd2: rgb = (m_h >= bx && m_h < bx + BOX && m_v >= by && m_v < by + BOX) ? col : bar_color(m_h);
          default: rgb = col;
        endcase
      end
      exp_q.push_back({hs, vs, de, rgb, de ? 16'(m_h) : 16'h0, de ? 16'(m_v) : 16'h0, fs});
      if (m_h == HT - 1 && m_v == VT - 1) m_frames++;
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end
    end
  endtask

  // driver: inputs change on the falling edge, expectation queued with them
  task automatic drive_cycle(input logic en, input logic [1:0] md, input logic [23:0] col);
    @(negedge clk);
    bus.en = en;
    bus.mode = md;
    bus.box_color = col;
    model_step(en, md, col);
    @(posedge clk);
  endtask

  function automatic logic [OW-1:0] dut_vec();
    return {bus.hs, bus.vs, bus.de, bus.rgb, bus.pix_x, bus.pix_y, bus.frame_start};
  endfunction

  task automatic check_idle(input string name);
    logic [OW-1:0] act;
    act = dut_vec();
    checks++;
    if (act !== idle_vec()) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, idle_vec());
    end
  endtask

  // monitor: one output pixel per clock, sampled 2 time units after the edge
  initial begin
    logic [OW-1:0] e, a, mask;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_vec();
        // pixel coordinates are only meaningful while de is high
        mask = e[OW-3] ? '1 : {{(3 + 24){1'b1}}, 32'h0, 1'b1};
        checks++;
        if ((a & mask) !== (e & mask)) begin
          errors++;
          $display("FAIL pixel t=%0t hs=%b/%b vs=%b/%b de=%b/%b rgb=%h/%h x=%0d/%0d y=%0d/%0d fs=%b/%b (got/want)",
                   $time, a[OW-1], e[OW-1], a[OW-2], e[OW-2], a[OW-3], e[OW-3],
                   a[56:33], e[56:33], a[32:17], e[32:17], a[16:1], e[16:1], a[0], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic        en;
    logic [1:0]  md;
    logic [23:0] col;
    int gap;
    int reset_at;

    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.box_color = 24'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_idle("reset_idle");
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_idle("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // two plain frames of colour bars
    for (int i = 0; i < 2 * FR; i++) drive_cycle(1'b1, 2'd0, 24'hFFB6C1);

    // random mode/colour/enable traffic, mostly bars-plus-box
    en = 1'b1; md = 2'd2; col = 24'hFFB6C1; gap = 0;
    reset_at = 20 * FR + $urandom_range(0, FR - 1);
    for (int i = 0; i < 44 * FR; i++) begin
      if (errors >= MAX_ERR) break;
      if ($urandom_range(0, 299) == 0)
        md = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      if ($urandom_range(0, 499) == 0) col = 24'($urandom);
      if (gap > 0) begin
        gap--;
        en = (gap == 0);
      end else if ($urandom_range(0, 1499) == 0) begin
        gap = $urandom_range(1, 40);
        en = 1'b0;
      end
      drive_cycle(en, md, col);
      if (i == reset_at) begin
        // asynchronous mid-frame reset between clock edges
        #3 rst_n = 1'b0;
        #1 check_idle("async_reset");
        model_reset();
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // checkerboard then solid colour, switched mid-frame
    for (int i = 0; i < 2 * FR + 137 && errors < MAX_ERR; i++) drive_cycle(1'b1, 2'd1, 24'h123456);
    for (int i = 0; i < 2 * FR && errors < MAX_ERR; i++) drive_cycle(1'b1, 2'd3, 24'hA5C3E7);

    // drain the expected queue with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #3;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
